// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;
    localparam int W_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIV_RUN = 2'd1,
        S_DIV_FIX = 2'd2
    } state_t;
endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, W steps after Load.
module div_core #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Load,
    input  logic [W-1:0] Dividend,
    input  logic [W-1:0] Divisor,
    output logic [W-1:0] Quotient,
    output logic [W-1:0] Remainder,
    output logic         Last
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  dsr;
    logic [CW-1:0] count;
    logic          active;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          geq;

    // Quotient doubles as the dividend shift register; its MSB feeds the partial remainder.
    assign shifted = {Remainder, Quotient[W-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign geq     = shifted >= {1'b0, dsr};
    assign Last    = active && (count == CW'(W - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Quotient  <= '0;
            Remainder <= '0;
            dsr       <= '0;
            count     <= '0;
            active    <= 1'b0;
        end else if (Load) begin
            Quotient  <= Dividend;
            Remainder <= '0;
            dsr       <= Divisor;
            count     <= '0;
            active    <= 1'b1;
        end else if (active) begin
            Remainder <= geq ? diff[W-1:0] : shifted[W-1:0];
            Quotient  <= {Quotient[W-2:0], geq};
            count     <= count + 1'b1;
            if (Last) active <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit with HI/LO; multiplies and moves take one edge, divides iterate under Busy.
module ex_muldiv_unit import muldiv_pkg::*; #(
    parameter int W = W_DEF
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [2:0]   Op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Hi,
    output logic [W-1:0] Lo,
    output logic         Busy,
    output logic         Done
);
    state_t       state;
    logic         qNeg, rNeg, divZero;
    logic [W-1:0] aRaw;

    logic [2*W-1:0] aS, bS, aU, bU, prodS, prodU, hiLo;
    logic           isDiv, divSigned, load;
    logic [W-1:0]   dividend, divisor, quotient, remainder;
    logic           last;

    // Low 2W bits of a 2W x 2W product of extended operands give the exact W x W product.
    assign aS    = {{W{A[W-1]}}, A};
    assign bS    = {{W{B[W-1]}}, B};
    assign aU    = {{W{1'b0}}, A};
    assign bU    = {{W{1'b0}}, B};
    assign prodS = aS * bS;
    assign prodU = aU * bU;
    assign hiLo  = {Hi, Lo};

    assign isDiv     = (Op == OP_DIV) || (Op == OP_DIVU);
    assign divSigned = (Op == OP_DIV);
    assign load      = (state == S_IDLE) && Start && isDiv;
    assign dividend  = (divSigned && A[W-1]) ? -A : A;
    assign divisor   = (divSigned && B[W-1]) ? -B : B;
    assign Busy      = (state != S_IDLE);

    div_core #(.W(W)) uDivCore (
        .Clk       (Clk),
        .Rst       (Rst),
        .Load      (load),
        .Dividend  (dividend),
        .Divisor   (divisor),
        .Quotient  (quotient),
        .Remainder (remainder),
        .Last      (last)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= S_IDLE;
            Hi      <= '0;
            Lo      <= '0;
            Done    <= 1'b0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
            divZero <= 1'b0;
            aRaw    <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: if (Start) begin
                    case (Op)
                        OP_MULT:  begin {Hi, Lo} <= prodS;        Done <= 1'b1; end
                        OP_MULTU: begin {Hi, Lo} <= prodU;        Done <= 1'b1; end
                        OP_MADD:  begin {Hi, Lo} <= hiLo + prodS; Done <= 1'b1; end
                        OP_MSUB:  begin {Hi, Lo} <= hiLo - prodS; Done <= 1'b1; end
                        OP_MTHI:  begin Hi <= A;                  Done <= 1'b1; end
                        OP_MTLO:  begin Lo <= A;                  Done <= 1'b1; end
                        OP_DIV, OP_DIVU: begin
                            qNeg    <= divSigned && (A[W-1] ^ B[W-1]);
                            rNeg    <= divSigned && A[W-1];
                            divZero <= (B == '0);
                            aRaw    <= A;
                            state   <= S_DIV_RUN;
                        end
                        default: ;
                    endcase
                end
                S_DIV_RUN: if (last) state <= S_DIV_FIX;
                S_DIV_FIX: begin
                    // Divide by zero bypasses sign fixup: all-ones quotient, raw dividend remainder.
                    if (divZero) begin
                        Lo <= '1;
                        Hi <= aRaw;
                    end else begin
                        Lo <= qNeg ? -quotient  : quotient;
                        Hi <= rNeg ? -remainder : remainder;
                    end
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: HI/LO arithmetic, divide latency/stall, divide-by-zero, reset abort.
module tb_ex_muldiv_unit;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A, B, Hi, Lo;
    logic        Busy, Done;

    int passCnt = 0;
    int total   = 0;

    ex_muldiv_unit #(.W(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    // Runs one divide, counting Busy cycles; optionally fires a stray Start and scrambles A/B mid-run.
    task automatic doDiv(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi,
                         input logic [31:0] expLo, input bit stray, input bit scramble);
        logic [31:0] preHi, preLo;
        int   busyCnt;
        bit   sawDone, stable;
        preHi = Hi; preLo = Lo;
        busyCnt = 0; sawDone = 0; stable = 1;
        issue(op, a, b);
        while (Busy && busyCnt < 100) begin
            busyCnt++;
            if (Done) sawDone = 1;
            if (Hi !== preHi || Lo !== preLo) stable = 0;
            if (stray && busyCnt == 5) begin Op = 3'd7; A = 32'h55; Start = 1'b1; end
            if (busyCnt == 6) Start = 1'b0;
            if (scramble && busyCnt == 3) begin A = $urandom; B = $urandom; end
            step();
        end
        chk({tag, " busy cycles"}, 32'(busyCnt), 32'd33);
        chk({tag, " done"}, 32'(Done), 32'd1);
        chk({tag, " hi"}, Hi, expHi);
        chk({tag, " lo"}, Lo, expLo);
        chk({tag, " quiet while busy"}, 32'({sawDone, stable}), 32'b01);
        step();
        chk({tag, " done drops"}, 32'(Done), 32'd0);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
        step(); step();
        chk("reset hi", Hi, 32'h0);
        chk("reset lo", Lo, 32'h0);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        Rst = 1'b0;
        step();

        issue(3'd0, 32'hFFFF_FFFF, 32'h2);
        chk("mult hi", Hi, 32'hFFFF_FFFF);
        chk("mult lo", Lo, 32'hFFFF_FFFE);
        chk("mult done", 32'(Done), 32'd1);
        step();
        chk("mult done drops", 32'(Done), 32'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        chk("multu hi", Hi, 32'h1);
        chk("multu lo", Lo, 32'hFFFF_FFFE);

        issue(3'd6, 32'h0, 32'h0);
        issue(3'd7, 32'd10, 32'h0);
        issue(3'd2, 32'd3, 32'd4);
        chk("madd hi", Hi, 32'h0);
        chk("madd lo", Lo, 32'd22);
        chk("madd busy", 32'(Busy), 32'd0);
        issue(3'd3, 32'd5, 32'd5);
        chk("msub hi", Hi, 32'hFFFF_FFFF);
        chk("msub lo", Lo, 32'hFFFF_FFFD);
        chk("msub done", 32'(Done), 32'd1);
        step();

        doDiv("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
        doDiv("divu ffffffff/16", 3'd5, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0, 1'b0);
        doDiv("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
        doDiv("div 100/-7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 1'b1);
        doDiv("divu 1234/0", 3'd5, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1'b0, 1'b1);

        issue(3'd4, 32'd100, 32'd7);
        chk("abort busy before", 32'(Busy), 32'd1);
        repeat (9) step();
        Rst = 1'b1;
        #1;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort hi", Hi, 32'h0);
        chk("abort lo", Lo, 32'h0);
        step();
        Rst = 1'b0;
        step();
        issue(3'd0, 32'd3, 32'd4);
        chk("post-reset mult lo", Lo, 32'd12);
        chk("post-reset mult hi", Hi, 32'h0);
        step();

        $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end
endmodule
